// File: rtl/ym3438_pkg.sv
// Shared sizes, write-kind encodings and write FSM states for the YM3438 detune sequencer.
package ym3438_pkg;

  localparam int NUM_SLOTS = 24;
  localparam int NUM_CH    = 6;
  localparam int NUM_OPS   = 4;
  localparam int DT_W      = 3;
  localparam int KC_W      = 5;

  localparam logic WR_KIND_DT = 1'b0;
  localparam logic WR_KIND_KC = 1'b1;

  typedef enum logic {
    WR_IDLE,
    WR_PEND
  } wr_state_e;

endpackage

// File: rtl/ym3438_slot_counter.sv
// Channel/op/slot counters advanced once per c2 step; also exposes the post-step values
// so the parent can look up table entries for the slot about to be presented.
module ym3438_slot_counter
  import ym3438_pkg::*;
(
  input  logic       MCLK,
  input  logic       reset,
  input  logic       c2,
  output logic [4:0] slot,
  output logic [2:0] channel,
  output logic [1:0] op,
  output logic       sync,
  output logic [4:0] next_slot,
  output logic [2:0] next_channel
);

  logic       ch_wrap;
  logic [1:0] next_op;

  // Channel and op are kept as separate counters so no divide is needed downstream.
  always_comb begin
    ch_wrap      = (channel == 3'(NUM_CH - 1));
    next_channel = ch_wrap ? 3'd0 : channel + 3'd1;
    next_op      = op;
    if (ch_wrap) begin
      next_op = (op == 2'(NUM_OPS - 1)) ? 2'd0 : op + 2'd1;
    end
    next_slot = (slot == 5'(NUM_SLOTS - 1)) ? 5'd0 : slot + 5'd1;
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      slot    <= 5'd0;
      channel <= 3'd0;
      op      <= 2'd0;
      sync    <= 1'b1;
    end else if (c2) begin
      slot    <= next_slot;
      channel <= next_channel;
      op      <= next_op;
      sync    <= (next_slot == 5'd0);
    end
  end

endmodule

// File: rtl/ym3438_dt_sequencer.sv
// Slot sequencer and DT/KCODE parameter store feeding the detune block; writes are deferred
// until their target slot or channel comes round so presented values are never torn.
module ym3438_dt_sequencer
  import ym3438_pkg::*;
(
  input  logic            MCLK,
  input  logic            reset,
  input  logic            c1,
  input  logic            c2,
  input  logic            wr_req,
  input  logic            wr_kind,
  input  logic [4:0]      wr_addr,
  input  logic [4:0]      wr_data,
  output logic            wr_busy,
  output logic            wr_ack,
  output logic            wr_err,
  output logic [4:0]      slot,
  output logic [2:0]      channel,
  output logic [1:0]      op,
  output logic            sync,
  output logic [DT_W-1:0] dt,
  output logic [KC_W-1:0] kcode
);

  logic [4:0] next_slot;
  logic [2:0] next_channel;

  ym3438_slot_counter u_counter (
    .MCLK         (MCLK),
    .reset        (reset),
    .c2           (c2),
    .slot         (slot),
    .channel      (channel),
    .op           (op),
    .sync         (sync),
    .next_slot    (next_slot),
    .next_channel (next_channel)
  );

  logic [DT_W-1:0] dt_tab [NUM_SLOTS];
  logic [KC_W-1:0] kc_tab [NUM_CH];

  wr_state_e  state_q, state_d;
  logic       pend_kind;
  logic [4:0] pend_addr;
  logic [4:0] pend_data;
  logic       addr_ok, hit, latch_en, commit, err_d;

  always_comb begin
    addr_ok  = (wr_kind == WR_KIND_DT) ? (wr_addr < 5'(NUM_SLOTS)) : (wr_addr < 5'(NUM_CH));
    hit      = (pend_kind == WR_KIND_DT) ? (pend_addr == slot) : (pend_addr == {2'b00, channel});
    state_d  = state_q;
    latch_en = 1'b0;
    commit   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (c1 && wr_req) begin
          if (addr_ok) begin
            latch_en = 1'b1;
            state_d  = WR_PEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // Requests arriving here are dropped; the commit compares against the pre-step slot.
      WR_PEND: begin
        if (c2 && hit) begin
          commit  = 1'b1;
          state_d = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q   <= WR_IDLE;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      pend_kind <= WR_KIND_DT;
      pend_addr <= 5'd0;
      pend_data <= 5'd0;
    end else begin
      state_q <= state_d;
      wr_ack  <= commit;
      wr_err  <= err_d;
      if (latch_en) begin
        pend_kind <= wr_kind;
        pend_addr <= wr_addr;
        pend_data <= wr_data;
      end
    end
  end

  assign wr_busy = (state_q == WR_PEND);

  always_ff @(posedge MCLK) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) dt_tab[i] <= '0;
      for (int i = 0; i < NUM_CH; i++)    kc_tab[i] <= '0;
    end else if (commit) begin
      if (pend_kind == WR_KIND_DT) dt_tab[pend_addr] <= pend_data[DT_W-1:0];
      else                         kc_tab[pend_addr[2:0]] <= pend_data;
    end
  end

  // The entry just committed belongs to the slot being left, so the lookup never needs a bypass.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      dt    <= '0;
      kcode <= '0;
    end else if (c2) begin
      dt    <= dt_tab[next_slot];
      kcode <= kc_tab[next_channel];
    end
  end

endmodule

// File: tb/tb_ym3438_dt_sequencer.sv
// Directed bench for ym3438_dt_sequencer: a slot-index model checks every cycle and
// hand-computed literals pin the key points of each scenario.
module tb_ym3438_dt_sequencer;

  logic       MCLK;
  logic       reset;
  logic       c1, c2, wr_req, wr_kind;
  logic [4:0] wr_addr, wr_data;
  logic       wr_busy, wr_ack, wr_err;
  logic [4:0] slot;
  logic [2:0] channel;
  logic [1:0] op;
  logic       sync;
  logic [2:0] dt;
  logic [4:0] kcode;

  ym3438_dt_sequencer dut (
    .MCLK    (MCLK),
    .reset   (reset),
    .c1      (c1),
    .c2      (c2),
    .wr_req  (wr_req),
    .wr_kind (wr_kind),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_busy (wr_busy),
    .wr_ack  (wr_ack),
    .wr_err  (wr_err),
    .slot    (slot),
    .channel (channel),
    .op      (op),
    .sync    (sync),
    .dt      (dt),
    .kcode   (kcode)
  );

  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  int checks = 0;
  int errors = 0;
  int ack_seen = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: position in the 24-slot pass, parameter tables and one pending write.
  int  m_pos;
  int  m_dt [24];
  int  m_kc [6];
  bit  m_pend, m_hit, m_ack, m_err, model_valid;
  int  m_kind, m_addr, m_data, m_outdt, m_outkc;

  initial model_valid = 1'b0;

  always @(posedge MCLK) begin
    if (reset) begin
      m_pos = 0;
      foreach (m_dt[i]) m_dt[i] = 0;
      foreach (m_kc[i]) m_kc[i] = 0;
      m_pend = 0; m_ack = 0; m_err = 0;
      m_outdt = 0; m_outkc = 0;
      model_valid = 1;
    end else begin
      m_ack = 0;
      m_err = 0;
      m_hit = m_pend && c2 && ((m_kind == 0) ? (m_addr == m_pos) : (m_addr == m_pos % 6));
      if (!m_pend && c1 && wr_req) begin
        if ((wr_kind == 1'b0 && int'(wr_addr) >= 24) || (wr_kind == 1'b1 && int'(wr_addr) >= 6)) begin
          m_err = 1;
        end else begin
          m_pend = 1;
          m_kind = int'(wr_kind);
          m_addr = int'(wr_addr);
          m_data = int'(wr_data);
        end
      end
      if (m_hit) begin
        if (m_kind == 0) m_dt[m_addr] = m_data % 8;
        else             m_kc[m_addr] = m_data;
        m_pend = 0;
        m_ack  = 1;
      end
      if (c2) begin
        m_pos   = (m_pos + 1) % 24;
        m_outdt = m_dt[m_pos];
        m_outkc = m_kc[m_pos % 6];
      end
    end
  end

  always @(negedge MCLK) begin
    if (wr_ack) ack_seen++;
    if (model_valid) begin
      checkOutput("slot",    int'(slot),    m_pos);
      checkOutput("channel", int'(channel), m_pos % 6);
      checkOutput("op",      int'(op),      m_pos / 6);
      checkOutput("sync",    int'(sync),    (m_pos == 0) ? 1 : 0);
      checkOutput("dt",      int'(dt),      m_outdt);
      checkOutput("kcode",   int'(kcode),   m_outkc);
      checkOutput("wr_busy", int'(wr_busy), int'(m_pend));
      checkOutput("wr_ack",  int'(wr_ack),  int'(m_ack));
      checkOutput("wr_err",  int'(wr_err),  int'(m_err));
    end
  end

  task automatic applyStimulus(input logic s_c1, input logic s_c2, input logic s_req,
                               input logic s_kind, input int s_addr, input int s_data);
    c1      = s_c1;
    c2      = s_c2;
    wr_req  = s_req;
    wr_kind = s_kind;
    wr_addr = 5'(s_addr);
    wr_data = 5'(s_data);
    @(posedge MCLK);
    #2;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  int acks_before;

  initial begin
    reset = 1'b1;
    c1 = 0; c2 = 0; wr_req = 0; wr_kind = 0; wr_addr = 0; wr_data = 0;
    idle();
    idle();
    reset = 1'b0;
    checkOutput("reset slot",  int'(slot),  0);
    checkOutput("reset sync",  int'(sync),  1);
    checkOutput("reset dt",    int'(dt),    0);
    checkOutput("reset kcode", int'(kcode), 0);
    checkOutput("reset busy",  int'(wr_busy), 0);

    idle();
    checkOutput("hold slot", int'(slot), 0);
    step(30);
    checkOutput("slot after 30", int'(slot), 6);
    checkOutput("sync after 30", int'(sync), 0);

    // DT write to slot 5 issued while slot 10 is presented
    step(4);
    checkOutput("at slot 10", int'(slot), 10);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5, 3);
    checkOutput("dt write busy", int'(wr_busy), 1);
    step(19);
    checkOutput("dt pend slot 5", int'(slot), 5);
    checkOutput("dt pend busy", int'(wr_busy), 1);
    checkOutput("dt pend no ack", int'(wr_ack), 0);
    step(1);
    checkOutput("dt ack", int'(wr_ack), 1);
    checkOutput("dt busy drop", int'(wr_busy), 0);
    checkOutput("dt slot 6 value", int'(dt), 0);
    idle();
    checkOutput("dt ack one cycle", int'(wr_ack), 0);
    step(23);
    checkOutput("dt visible slot", int'(slot), 5);
    checkOutput("dt visible value", int'(dt), 3);

    // KCODE write to channel 2 issued at slot 7
    step(2);
    checkOutput("slot 7 dt", int'(dt), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2, 5'h1B);
    checkOutput("kc busy", int'(wr_busy), 1);
    step(1);
    checkOutput("kc slot 8 old", int'(kcode), 0);
    checkOutput("kc still busy", int'(wr_busy), 1);
    step(1);
    checkOutput("kc ack", int'(wr_ack), 1);
    step(5);
    checkOutput("kc slot 14", int'(kcode), 8'h1B);
    step(1);
    checkOutput("kc slot 15", int'(kcode), 0);

    // Out-of-range requests
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 24, 7);
    checkOutput("err dt addr", int'(wr_err), 1);
    checkOutput("err dt busy", int'(wr_busy), 0);
    idle();
    checkOutput("err one cycle", int'(wr_err), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 6, 9);
    checkOutput("err kc addr", int'(wr_err), 1);
    checkOutput("err kc busy", int'(wr_busy), 0);
    idle();

    // Second request while pending, then commit colliding with a third request
    acks_before = ack_seen;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 12, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 13, 7);
    checkOutput("ignored req err", int'(wr_err), 0);
    checkOutput("ignored req busy", int'(wr_busy), 1);
    step(21);
    checkOutput("at slot 12", int'(slot), 12);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 14, 6);
    checkOutput("collide ack", int'(wr_ack), 1);
    idle();
    checkOutput("collide req dropped", int'(wr_busy), 0);
    step(23);
    checkOutput("first data slot 12", int'(dt), 5);
    step(1);
    checkOutput("slot 13 untouched", int'(dt), 0);
    step(1);
    checkOutput("slot 14 untouched", int'(dt), 0);
    checkOutput("single ack", ack_seen - acks_before, 1);

    // Reset while a DT write to slot 3 is pending
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3, 4);
    checkOutput("pend before reset", int'(wr_busy), 1);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checkOutput("reset pend slot", int'(slot), 0);
    checkOutput("reset pend busy", int'(wr_busy), 0);
    checkOutput("reset pend ack", int'(wr_ack), 0);
    idle();
    checkOutput("reset no late ack", int'(wr_ack), 0);
    step(3);
    checkOutput("reset slot 3 dt", int'(dt), 0);
    step(24);
    checkOutput("reset slot 3 next pass", int'(dt), 0);
    checkOutput("reset kc cleared", int'(kcode), 0);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
